// File: rtl/ps2_key_decoder.sv
// PS/2 device-to-host receiver: synchronises and deglitches the lines, frames bytes,
// and folds E0/F0 prefixes into a toggling 11-bit key-event word.
module ps2_key_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 36000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_filt, r_filt_d;
  logic [FW-1:0] r_fcnt;
  logic [TW-1:0] r_tcnt;
  state_t        r_state, w_state_nx;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic          r_ext, r_rel;
  logic          r_acc_vld;
  logic [7:0]    r_acc_byte;
  logic [10:0]   r_key;
  logic          r_frame_err;

  logic w_strobe, w_timeout, w_active;
  logic w_err, w_accept, w_drop, w_shift_en, w_par_en;

  assign w_strobe  = r_filt_d & ~r_filt;
  assign w_active  = (r_state != S_IDLE) | r_ext | r_rel;
  assign w_timeout = (r_tcnt == TW'(TIMEOUT));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_clk_s1 <= ps2_clk_in;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data_in;
      r_dat_s2 <= r_dat_s1;
      r_filt_d <= r_filt;
      // Level flips on the FILTER_LEN-th consecutive differing sample.
      if (r_clk_s2 == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
        r_filt <= r_clk_s2;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_err      = 1'b0;
    w_accept   = 1'b0;
    w_drop     = 1'b0;
    w_shift_en = 1'b0;
    w_par_en   = 1'b0;
    if (w_timeout) begin
      w_state_nx = S_IDLE;
      w_err      = (r_state != S_IDLE);
    end else if (w_strobe) begin
      case (r_state)
        S_IDLE: begin
          if (!r_dat_s2) w_state_nx = S_DATA;
          else           w_err      = 1'b1;
        end
        S_DATA: begin
          w_shift_en = 1'b1;
          if (r_bitcnt == 3'd7) w_state_nx = S_PARITY;
        end
        S_PARITY: begin
          w_par_en   = 1'b1;
          w_state_nx = S_STOP;
        end
        S_STOP: begin
          w_state_nx = S_IDLE;
          if (r_dat_s2 && (^{r_shift, r_par})) begin
            w_accept = 1'b1;
          end else begin
            w_err  = 1'b1;
            w_drop = 1'b1;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_tcnt      <= '0;
      r_acc_vld   <= 1'b0;
      r_acc_byte  <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_frame_err <= w_err;
      r_acc_vld   <= w_accept;
      if (w_accept) r_acc_byte <= r_shift;
      if (w_strobe && r_state == S_IDLE) r_bitcnt <= '0;
      if (w_shift_en) begin
        r_shift  <= {r_dat_s2, r_shift[7:1]};
        r_bitcnt <= r_bitcnt + 1'b1;
      end
      if (w_par_en) r_par <= r_dat_s2;
      if (w_strobe || !w_active || w_timeout) r_tcnt <= '0;
      else                                    r_tcnt <= r_tcnt + 1'b1;
    end
  end

  // Prefix flags persist across frames until a non-prefix byte, a bad frame or a timeout.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_ext <= 1'b0;
      r_rel <= 1'b0;
      r_key <= '0;
    end else if (w_timeout || w_drop) begin
      r_ext <= 1'b0;
      r_rel <= 1'b0;
    end else if (r_acc_vld) begin
      if (r_acc_byte == 8'hE0) begin
        r_ext <= 1'b1;
      end else if (r_acc_byte == 8'hF0) begin
        r_rel <= 1'b1;
      end else begin
        r_key <= {~r_key[10], ~r_rel, r_ext, r_acc_byte};
        r_ext <= 1'b0;
        r_rel <= 1'b0;
      end
    end
  end

  assign ps2_key   = r_key;
  assign frame_err = r_frame_err;

endmodule
